mdu: RTL and testbench

RV32M multiply/divide unit in the execute stage. Takes `o_rs1_data`/`o_rs2_data` read from the register file, computes the M-extension result, and drives the register file write port (`i_rd_wren`/`i_rd_addr`/`i_rd_data`) for one cycle when the result is ready. Division is iterative; multiplication is single-cycle or iterative, selected at compile time. The pipeline stalls on `o_busy`.

---
 rtl/mdu_pkg.sv | 24 ++
 rtl/mdu_iter_core.sv | 54 +++++
 rtl/mdu.sv | 158 +++++++++++++++
 tb/tb_mdu.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
package mdu_pkg;

   typedef enum logic [2:0] {
      MUL    = 3'b000,
      MULH   = 3'b001,
      MULHSU = 3'b010,
      MULHU  = 3'b011,
      DIV    = 3'b100,
      DIVU   = 3'b101,
      REM    = 3'b110,
      REMU   = 3'b111
   } mdu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } mdu_state_e;

   localparam int          MDU_ITER = 32;
   localparam logic [31:0] DIV0_Q   = 32'hFFFF_FFFF;

endpackage

// File: rtl/mdu_iter_core.sv
// Shared iterative datapath: restoring divide or shift-add multiply, one bit per step,
// over a 64-bit accumulator with a down-counter that flags the final step.
module mdu_iter_core
   import mdu_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        load,
   input  logic        step,
   input  logic        is_div,
   input  logic [31:0] init_lo,
   input  logic [31:0] operand,
   output logic [63:0] acc_next,
   output logic        last
);

   logic [63:0] acc_q;
   logic [31:0] opnd_q;
   logic        div_q;
   logic [4:0]  cnt_q;
   logic [33:0] trial;
   logic [32:0] sum;

   // Divide: acc = {remainder, dividend/quotient}. Multiply: acc = {partial high, multiplier}.
   always_comb begin
      trial = {1'b0, acc_q[63:31]} - {2'b00, opnd_q};
      sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
      if (div_q)
         acc_next = trial[33] ? {acc_q[62:0], 1'b0} : {trial[31:0], acc_q[30:0], 1'b1};
      else
         acc_next = {sum, acc_q[31:1]};
   end

   assign last = (cnt_q == 5'd0);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         acc_q  <= '0;
         opnd_q <= '0;
         div_q  <= 1'b0;
         cnt_q  <= '0;
      end else if (load) begin
         acc_q  <= {32'd0, init_lo};
         opnd_q <= operand;
         div_q  <= is_div;
         cnt_q  <= 5'(MDU_ITER - 1);
      end else if (step) begin
         acc_q <= acc_next;
         if (cnt_q != 5'd0)
            cnt_q <= cnt_q - 5'd1;
      end
   end

endmodule

// File: rtl/mdu.sv
// RV32M multiply/divide unit: FSM, operand conditioning, sign fix and registered write port.
// Define MDU_FAST_MUL_EN to compile in a single-cycle 33x33 multiplier for the MUL* ops.
//
//   state | meaning
//   IDLE  | waiting for i_start
//   CALC  | iterating, one result bit per cycle (32 cycles)
//   DONE  | result registered on the outputs, o_done high
module mdu
   import mdu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_start,
   input  logic            i_kill,
   input  logic [2:0]      i_funct3,
   input  logic [XLEN-1:0] i_rs1_data,
   input  logic [XLEN-1:0] i_rs2_data,
   input  logic [4:0]      i_rd_addr,
   output logic            o_busy,
   output logic            o_done,
   output logic            o_rd_wren,
   output logic [4:0]      o_rd_addr,
   output logic [XLEN-1:0] o_rd_data
);

   mdu_state_e      state_q, state_d;
   mdu_op_e         op_in, op_q;
   logic [4:0]      rd_q, addr_d;
   logic            neg_q, neg_in, rs1_neg, rs2_neg;
   logic            is_div_in, div0, ovf, fast, accept;
   logic            core_load, core_step, core_last;
   logic [XLEN-1:0] mag_a, mag_b, fast_res, iter_res, res_d, core_lo, core_opnd;
   logic [63:0]     core_next, prod_fix;

`ifdef MDU_FAST_MUL_EN
   logic signed [32:0] mul_a, mul_b;
   logic signed [65:0] mul_p;

   always_comb begin
      mul_a = {rs1_neg, i_rs1_data};
      mul_b = {rs2_neg, i_rs2_data};
      mul_p = mul_a * mul_b;
   end
`endif

   always_comb begin
      op_in     = mdu_op_e'(i_funct3);
      is_div_in = i_funct3[2];
      rs1_neg   = i_rs1_data[XLEN-1] & (op_in inside {MULH, MULHSU, DIV, REM});
      rs2_neg   = i_rs2_data[XLEN-1] & (op_in inside {MULH, DIV, REM});
      mag_a     = rs1_neg ? -i_rs1_data : i_rs1_data;
      mag_b     = rs2_neg ? -i_rs2_data : i_rs2_data;
      // Remainder follows the dividend; everything else follows the sign product.
      neg_in    = (op_in == REM) ? rs1_neg : (rs1_neg ^ rs2_neg);
      div0      = is_div_in && (i_rs2_data == '0);
      ovf       = (op_in inside {DIV, REM}) && (i_rs1_data == 32'h8000_0000) &&
                  (i_rs2_data == 32'hFFFF_FFFF);
      fast_res  = '0;
      if (div0)
         fast_res = i_funct3[1] ? i_rs1_data : DIV0_Q;
      else if (ovf)
         fast_res = i_funct3[1] ? 32'h0000_0000 : 32'h8000_0000;
`ifdef MDU_FAST_MUL_EN
      else if (!is_div_in)
         fast_res = (op_in == MUL) ? mul_p[31:0] : mul_p[63:32];
      fast = div0 | ovf | !is_div_in;
`else
      fast = div0 | ovf;
`endif
      core_lo   = is_div_in ? mag_a : mag_b;
      core_opnd = is_div_in ? mag_b : mag_a;
   end

   always_comb begin
      prod_fix = neg_q ? -core_next : core_next;
      unique case (op_q)
         MUL:                iter_res = core_next[31:0];
         MULH, MULHSU, MULHU: iter_res = prod_fix[63:32];
         DIV, DIVU:          iter_res = neg_q ? -core_next[31:0] : core_next[31:0];
         default:            iter_res = neg_q ? -core_next[63:32] : core_next[63:32];
      endcase
   end

   always_comb begin
      state_d   = state_q;
      accept    = 1'b0;
      core_load = 1'b0;
      core_step = 1'b0;
      unique case (state_q)
         IDLE, DONE: begin
            if (i_start) begin
               accept    = 1'b1;
               core_load = !fast;
               state_d   = fast ? DONE : CALC;
            end else begin
               state_d = IDLE;
            end
         end
         CALC: begin
            core_step = 1'b1;
            if (core_last)
               state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
      if (i_kill) begin
         state_d   = IDLE;
         accept    = 1'b0;
         core_load = 1'b0;
         core_step = 1'b0;
      end
      addr_d = accept ? i_rd_addr : rd_q;
      res_d  = accept ? fast_res : iter_res;
   end

   mdu_iter_core u_core (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .load     (core_load),
      .step     (core_step),
      .is_div   (is_div_in),
      .init_lo  (core_lo),
      .operand  (core_opnd),
      .acc_next (core_next),
      .last     (core_last)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= IDLE;
         op_q      <= MUL;
         rd_q      <= '0;
         neg_q     <= 1'b0;
         o_busy    <= 1'b0;
         o_done    <= 1'b0;
         o_rd_wren <= 1'b0;
         o_rd_addr <= '0;
         o_rd_data <= '0;
      end else begin
         state_q   <= state_d;
         o_busy    <= (state_d == CALC);
         o_done    <= (state_d == DONE);
         o_rd_wren <= (state_d == DONE) && (addr_d != 5'd0);
         if (accept) begin
            op_q  <= op_in;
            rd_q  <= i_rd_addr;
            neg_q <= neg_in;
         end
         if (state_d == DONE) begin
            o_rd_addr <= addr_d;
            o_rd_data <= res_d;
         end
      end
   end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: vector table plus kill, reset and back-to-back sequences,
// with expected results queued at issue and compared when o_done appears.
module tb_mdu;

   localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
   localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;
`ifdef MDU_FAST_MUL_EN
   localparam int ML = 1;
`else
   localparam int ML = 33;
`endif
   localparam int NV = 20;

   logic        i_clk = 1'b0, i_rst_n = 1'b0, i_start = 1'b0, i_kill = 1'b0;
   logic [2:0]  i_funct3 = '0;
   logic [31:0] i_rs1_data = '0, i_rs2_data = '0;
   logic [4:0]  i_rd_addr = '0;
   logic        o_busy, o_done, o_rd_wren;
   logic [4:0]  o_rd_addr;
   logic [31:0] o_rd_data;

   mdu #(.XLEN(32)) dut (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_start    (i_start),
      .i_kill     (i_kill),
      .i_funct3   (i_funct3),
      .i_rs1_data (i_rs1_data),
      .i_rs2_data (i_rs2_data),
      .i_rd_addr  (i_rd_addr),
      .o_busy     (o_busy),
      .o_done     (o_done),
      .o_rd_wren  (o_rd_wren),
      .o_rd_addr  (o_rd_addr),
      .o_rd_data  (o_rd_data)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [31:0] data;
      logic [4:0]  addr;
      logic        wren;
      int          start;
      int          lat;
   } sb_t;

   typedef struct {
      string       name;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   sb_t  sb[$];
   sb_t  mon_e;
   int   n_vec = 0, n_bad = 0, cycle = 0;

   always @(posedge i_clk) cycle++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   always @(negedge i_clk) begin
      if (i_rst_n && o_done) begin
         if (sb.size() == 0) begin
            check("unexpected_done", {27'd0, o_rd_addr}, 32'hFFFF_FFFF);
         end else begin
            mon_e = sb.pop_front();
            check("rd_data", o_rd_data, mon_e.data);
            check("rd_addr", {27'd0, o_rd_addr}, {27'd0, mon_e.addr});
            check("rd_wren", {31'd0, o_rd_wren}, {31'd0, mon_e.wren});
            check("latency", 32'(cycle - mon_e.start), 32'(mon_e.lat));
         end
      end
   end

   // Called at a falling edge; returns at the next falling edge with i_start dropped.
   task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input int lat,
                        input bit track);
      sb_t e;
      i_start    = 1'b1;
      i_funct3   = f3;
      i_rs1_data = a;
      i_rs2_data = b;
      i_rd_addr  = rd;
      if (track) begin
         e.data  = exp;
         e.addr  = rd;
         e.wren  = (rd != 5'd0);
         e.start = cycle;
         e.lat   = lat;
         sb.push_back(e);
      end
      @(negedge i_clk);
      i_start = 1'b0;
   endtask

   task automatic wait_done(input string name, output int busy_cycles);
      int n = 0;
      busy_cycles = 0;
      while (n < 40 && !o_done) begin
         busy_cycles += int'(o_busy);
         @(negedge i_clk);
         n++;
      end
      check({name, "_done_seen"}, {31'd0, o_done}, 32'd1);
   endtask

   initial begin
      vec_t tbl[NV];
      int   bc, dc;

      tbl[0]  = '{"div_neg",     F_DIV,    32'hFFFF_FFEC, 32'd3,         5'd5,  32'hFFFF_FFFA, 33};
      tbl[1]  = '{"rem_neg",     F_REM,    32'hFFFF_FFEC, 32'd3,         5'd6,  32'hFFFF_FFFE, 33};
      tbl[2]  = '{"remu_div0",   F_REMU,   32'd20,        32'd0,         5'd1,  32'd20,        1};
      tbl[3]  = '{"divu_div0",   F_DIVU,   32'd7,         32'd0,         5'd2,  32'hFFFF_FFFF, 1};
      tbl[4]  = '{"div_ovf",     F_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd3,  32'h8000_0000, 1};
      tbl[5]  = '{"rem_ovf",     F_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd4,  32'd0,         1};
      tbl[6]  = '{"mulh_m1",     F_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'd0,         ML};
      tbl[7]  = '{"mulhu_max",   F_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9,  32'hFFFF_FFFE, ML};
      tbl[8]  = '{"mul_lo",      F_MUL,    32'h1234_5678, 32'h10,        5'd10, 32'h2345_6780, ML};
      tbl[9]  = '{"mulhsu_neg",  F_MULHSU, 32'hFFFF_FFFF, 32'd2,         5'd11, 32'hFFFF_FFFF, ML};
      tbl[10] = '{"mulh_min",    F_MULH,   32'h8000_0000, 32'h8000_0000, 5'd12, 32'h4000_0000, ML};
      tbl[11] = '{"divu_100_7",  F_DIVU,   32'd100,       32'd7,         5'd13, 32'd14,        33};
      tbl[12] = '{"remu_100_7",  F_REMU,   32'd100,       32'd7,         5'd14, 32'd2,         33};
      tbl[13] = '{"div_negdiv",  F_DIV,    32'd20,        32'hFFFF_FFFD, 5'd15, 32'hFFFF_FFFA, 33};
      tbl[14] = '{"rem_negdiv",  F_REM,    32'd20,        32'hFFFF_FFFD, 5'd16, 32'd2,         33};
      tbl[15] = '{"div_s_div0",  F_DIV,    32'hFFFF_FFEC, 32'd0,         5'd17, 32'hFFFF_FFFF, 1};
      tbl[16] = '{"rem_s_div0",  F_REM,    32'hFFFF_FFEC, 32'd0,         5'd18, 32'hFFFF_FFEC, 1};
      tbl[17] = '{"mul_neg",     F_MUL,    32'hFFFF_FFFD, 32'd7,         5'd19, 32'hFFFF_FFEB, ML};
      tbl[18] = '{"divu_by1",    F_DIVU,   32'hFFFF_FFFF, 32'd1,         5'd20, 32'hFFFF_FFFF, 33};
      tbl[19] = '{"mulhu_pow",   F_MULHU,  32'h8000_0000, 32'd2,         5'd21, 32'd1,         ML};

      repeat (3) @(negedge i_clk);
      check("rst_busy", {31'd0, o_busy}, 32'd0);
      check("rst_done", {31'd0, o_done}, 32'd0);
      check("rst_wren", {31'd0, o_rd_wren}, 32'd0);
      check("rst_addr", {27'd0, o_rd_addr}, 32'd0);
      check("rst_data", o_rd_data, 32'd0);
      i_rst_n = 1'b1;
      @(negedge i_clk);

      for (int i = 0; i < NV; i++) begin
         issue(tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].exp, tbl[i].lat, 1'b1);
         wait_done(tbl[i].name, bc);
         check({tbl[i].name, "_busy_cycles"}, 32'(bc), 32'(tbl[i].lat - 1));
         @(negedge i_clk);
      end

      // rd=0 suppresses the write; a start in the DONE cycle chains the next op.
      issue(F_DIVU, 32'd9, 32'd3, 5'd0, 32'd3, 33, 1'b1);
      wait_done("b2b_first", bc);
      issue(F_DIVU, 32'd9, 32'd3, 5'd7, 32'd3, 33, 1'b1);
      wait_done("b2b_second", bc);
      check("b2b_second_busy_cycles", 32'(bc), 32'd32);
      @(negedge i_clk);

      // Kill in cycle k+10 of a divide.
      issue(F_DIV, 32'hFFFF_FFEC, 32'd3, 5'd5, 32'd0, 33, 1'b0);
      repeat (9) @(negedge i_clk);
      check("kill_busy_before", {31'd0, o_busy}, 32'd1);
      i_kill = 1'b1;
      @(negedge i_clk);
      i_kill = 1'b0;
      check("kill_busy_after", {31'd0, o_busy}, 32'd0);
      dc = 0;
      repeat (40) begin
         dc += int'(o_done) + int'(o_rd_wren);
         @(negedge i_clk);
      end
      check("kill_no_result", 32'(dc), 32'd0);

      // Reset in cycle k+5 of a divide clears every output at once.
      issue(F_DIV, 32'hFFFF_FFEC, 32'd3, 5'd5, 32'd0, 33, 1'b0);
      repeat (4) @(negedge i_clk);
      check("mid_rst_busy_before", {31'd0, o_busy}, 32'd1);
      i_rst_n = 1'b0;
      #1;
      check("mid_rst_busy", {31'd0, o_busy}, 32'd0);
      check("mid_rst_done", {31'd0, o_done}, 32'd0);
      check("mid_rst_wren", {31'd0, o_rd_wren}, 32'd0);
      check("mid_rst_addr", {27'd0, o_rd_addr}, 32'd0);
      check("mid_rst_data", o_rd_data, 32'd0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      dc = 0;
      repeat (40) begin
         dc += int'(o_done);
         @(negedge i_clk);
      end
      check("mid_rst_no_done", 32'(dc), 32'd0);

      issue(F_DIVU, 32'd100, 32'd7, 5'd13, 32'd14, 33, 1'b1);
      wait_done("post_rst_divu", bc);
      @(negedge i_clk);

      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d, required completion", cycle);
      $fatal(1);
   end

endmodule
